// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR read-request arbiter: FSM state encoding and
// the default channel-index width derived from the channel count.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_t;

    localparam int N_CH_DEF = 3;

    function automatic int ch_w_for(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    localparam int CH_W_DEF = ch_w_for(N_CH_DEF);

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// Command and read-data bus between the arbiter (master) and mig_axi (slave).
interface ddr_rd_arbiter_if #(
    parameter int DDR_ADDR_LEN = 32,
    parameter int SINGLE_LEN   = 24,
    parameter int DDR_DATA_LEN = 512
);

    // ddr_conf is a one-cycle command pulse carrying addr/len; no back-pressure.
    // A beat transfers in every cycle ddr_fifo_req is high, which the master
    // only raises while ddr_fifo_empty is low (data is valid when not empty).
    logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
    logic [SINGLE_LEN-1:0]   ddr_len;
    logic                    ddr_conf;
    logic                    ddr_fifo_empty;
    logic                    ddr_fifo_req;
    logic [DDR_DATA_LEN-1:0] ddr_fifo_data;

    modport master (
        output ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_req,
        input  ddr_fifo_empty, ddr_fifo_data
    );

    modport slave (
        input  ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_req,
        output ddr_fifo_empty, ddr_fifo_data
    );

endinterface

// File: rtl/ddr_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 3,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] eligible,
    input  logic [CH_W-1:0] rr_ptr,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_vld
);

    localparam logic [CH_W:0] N_CH_W = (CH_W + 1)'(N_CH);

    logic [2*N_CH-1:0] dbl;
    logic [2*N_CH-1:0] rot;
    logic [CH_W-1:0]   offs;
    logic [CH_W:0]     sum;
    logic [CH_W:0]     sum_wrap;

    // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit
    // of the rotated window is the distance to the winner.
    always_comb begin
        dbl       = {eligible, eligible};
        rot       = dbl >> rr_ptr;
        grant_vld = 1'b0;
        offs      = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_vld = 1'b1;
                offs      = CH_W'(k);
            end
        end
        sum       = {1'b0, rr_ptr} + {1'b0, offs};
        sum_wrap  = (sum >= N_CH_W) ? (sum - N_CH_W) : sum;
        grant_idx = sum_wrap[CH_W-1:0];
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// N-channel DDR read-request arbiter: per-channel request slots, round-robin or
// forced grant, one command per grant to mig_axi, beat counting, done/error status.
module ddr_rd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int N_CH         = N_CH_DEF,
    parameter int DDR_ADDR_LEN = 32,
    parameter int SINGLE_LEN   = 24,
    parameter int DDR_DATA_LEN = 512,
    parameter int CH_W         = CH_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arb_mode,
    input  logic [CH_W-1:0]              force_ch,
    input  logic [N_CH*DDR_ADDR_LEN-1:0] ch_st_addr,
    input  logic [N_CH*SINGLE_LEN-1:0]   ch_len,
    input  logic [N_CH-1:0]              ch_conf,
    output logic [N_CH-1:0]              ch_busy,
    output logic [N_CH-1:0]              ch_done,
    output logic [N_CH-1:0]              ch_err,
    output logic [N_CH-1:0]              ch_fifo_empty,
    input  logic [N_CH-1:0]              ch_fifo_req,
    output logic [DDR_DATA_LEN-1:0]      ch_fifo_data,
    ddr_rd_arbiter_if.master             ddr,
    output arb_state_t                   dbg_state
);

    logic [DDR_ADDR_LEN-1:0] slot_addr [N_CH];
    logic [SINGLE_LEN-1:0]   slot_len  [N_CH];

    arb_state_t            state;
    logic [CH_W-1:0]       g;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       next_ptr;
    logic [SINGLE_LEN-1:0] beats_left;
    logic [N_CH-1:0]       eligible;
    logic [CH_W-1:0]       arb_idx;
    logic                  arb_vld;
    logic                  streaming;

    // Forced mode narrows eligibility to force_ch; an out-of-range force_ch matches nothing.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = ch_busy[i] & (~arb_mode | (force_ch == CH_W'(i)));
        end
    end

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign streaming        = (state == ST_STREAM);
    assign next_ptr         = (g == CH_W'(N_CH - 1)) ? '0 : g + 1'b1;
    assign ddr.ddr_fifo_req = streaming & ch_fifo_req[g] & ~ddr.ddr_fifo_empty;
    assign ch_fifo_data     = ddr.ddr_fifo_data;
    assign dbg_state        = state;

    always_comb begin
        ch_fifo_empty = '1;
        if (streaming) begin
            ch_fifo_empty[g] = ddr.ddr_fifo_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            g                   <= '0;
            rr_ptr              <= '0;
            beats_left          <= '0;
            ch_busy             <= '0;
            ch_done             <= '0;
            ch_err              <= '0;
            ddr.ddr_conf        <= 1'b0;
            ddr.ddr_st_addr_out <= '0;
            ddr.ddr_len         <= '0;
            for (int i = 0; i < N_CH; i++) begin
                slot_addr[i] <= '0;
                slot_len[i]  <= '0;
            end
        end else begin
            ch_done      <= '0;
            ddr.ddr_conf <= 1'b0;

            // Captures run every cycle; a busy channel never collides with a clear below.
            for (int i = 0; i < N_CH; i++) begin
                if (ch_conf[i]) begin
                    if (ch_busy[i]) begin
                        ch_err[i] <= 1'b1;
                    end else begin
                        ch_busy[i]   <= 1'b1;
                        slot_addr[i] <= ch_st_addr[i*DDR_ADDR_LEN +: DDR_ADDR_LEN];
                        slot_len[i]  <= ch_len[i*SINGLE_LEN +: SINGLE_LEN];
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        g     <= arb_idx;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ddr.ddr_st_addr_out <= slot_addr[g];
                    ddr.ddr_len         <= slot_len[g];
                    beats_left          <= slot_len[g];
                    if (slot_len[g] == '0) begin
                        ch_done[g] <= 1'b1;
                        ch_busy[g] <= 1'b0;
                        rr_ptr     <= next_ptr;
                        state      <= ST_IDLE;
                    end else begin
                        ddr.ddr_conf <= 1'b1;
                        state        <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (ddr.ddr_fifo_req) begin
                        if (beats_left == SINGLE_LEN'(1)) begin
                            ch_done[g] <= 1'b1;
                            ch_busy[g] <= 1'b0;
                            rr_ptr     <= next_ptr;
                            state      <= ST_IDLE;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter: expected commands and completions are queued
// as stimulus is issued; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_ddr_rd_arbiter;
    import ddr_arb_pkg::*;

    localparam int N_CH = 3;
    localparam int AW   = 32;
    localparam int LW   = 24;
    localparam int DW   = 512;
    localparam int CW   = 2;

    // clock / reset and DUT inputs
    logic                 clk        = 1'b0;
    logic                 rst_n      = 1'b0;
    logic                 arb_mode   = 1'b0;
    logic [CW-1:0]        force_ch   = '0;
    logic [N_CH*AW-1:0]   ch_st_addr = '0;
    logic [N_CH*LW-1:0]   ch_len     = '0;
    logic [N_CH-1:0]      ch_conf    = '0;
    logic [N_CH-1:0]      ch_fifo_req = '1;
    logic [N_CH-1:0]      ch_busy;
    logic [N_CH-1:0]      ch_done;
    logic [N_CH-1:0]      ch_err;
    logic [N_CH-1:0]      ch_fifo_empty;
    logic [DW-1:0]        ch_fifo_data;
    arb_state_t           dbg_state;

    ddr_rd_arbiter_if #(.DDR_ADDR_LEN(AW), .SINGLE_LEN(LW), .DDR_DATA_LEN(DW)) ddr_if ();

    ddr_rd_arbiter #(
        .N_CH(N_CH), .DDR_ADDR_LEN(AW), .SINGLE_LEN(LW), .DDR_DATA_LEN(DW), .CH_W(CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arb_mode      (arb_mode),
        .force_ch      (force_ch),
        .ch_st_addr    (ch_st_addr),
        .ch_len        (ch_len),
        .ch_conf       (ch_conf),
        .ch_busy       (ch_busy),
        .ch_done       (ch_done),
        .ch_err        (ch_err),
        .ch_fifo_empty (ch_fifo_empty),
        .ch_fifo_req   (ch_fifo_req),
        .ch_fifo_data  (ch_fifo_data),
        .ddr           (ddr_if),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    // scoreboard state
    int n_checks = 0;
    int n_errors = 0;
    logic [AW+LW-1:0]   conf_exp_q [$];
    logic [N_CH+LW-1:0] done_exp_q [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [DW-1:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // mig_axi read-FIFO model: data word encodes the running pop index
    logic        toggle_en = 1'b0;
    logic [31:0] model_idx = '0;
    logic        popped;
    initial begin
        ddr_if.ddr_fifo_empty = 1'b0;
        ddr_if.ddr_fifo_data  = '0;
        forever begin
            @(negedge clk);
            popped = ddr_if.ddr_fifo_req;
            @(posedge clk);
            #1;
            if (popped) model_idx++;
            ddr_if.ddr_fifo_data  = {16{model_idx}};
            ddr_if.ddr_fifo_empty = toggle_en ? ~ddr_if.ddr_fifo_empty : 1'b0;
        end
    end

    // monitor
    logic [31:0] mon_idx   = '0;
    int          svc_beats = 0;
    always @(negedge clk) begin
        if (ddr_if.ddr_fifo_req) begin
            check("fifo_data", ch_fifo_data, {16{mon_idx}});
            mon_idx++;
            svc_beats++;
        end
        if (!rst_n) svc_beats = 0;
        if (ddr_if.ddr_conf) begin
            if (conf_exp_q.size() == 0)
                fail_unexpected("ddr_conf", DW'({ddr_if.ddr_st_addr_out, ddr_if.ddr_len}));
            else
                check("ddr_cmd", DW'({ddr_if.ddr_st_addr_out, ddr_if.ddr_len}), DW'(conf_exp_q.pop_front()));
        end
        if (ch_done != '0) begin
            if (done_exp_q.size() == 0)
                fail_unexpected("ch_done", DW'(ch_done));
            else
                check("done_beats", DW'({ch_done, LW'(svc_beats)}), DW'(done_exp_q.pop_front()));
            check("busy_clear_on_done", DW'(ch_busy & ch_done), '0);
            svc_beats = 0;
        end
    end

    // driver tasks
    task automatic set_ch(input int ch, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        ch_st_addr[ch*AW +: AW] = addr;
        ch_len[ch*LW +: LW]     = len;
    endtask

    task automatic pulse(input logic [N_CH-1:0] mask);
        ch_conf = mask;
        @(negedge clk);
        ch_conf = '0;
    endtask

    task automatic expect_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        conf_exp_q.push_back({addr, len});
    endtask

    task automatic expect_done(input logic [N_CH-1:0] mask, input logic [LW-1:0] beats);
        done_exp_q.push_back({mask, beats});
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((conf_exp_q.size() != 0 || done_exp_q.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain", DW'(conf_exp_q.size() + done_exp_q.size()), '0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  DW'(ch_busy), '0);
        check({tag, "_done"},  DW'(ch_done), '0);
        check({tag, "_err"},   DW'(ch_err), '0);
        check({tag, "_empty"}, DW'(ch_fifo_empty), DW'(3'b111));
        check({tag, "_conf"},  DW'(ddr_if.ddr_conf), '0);
        check({tag, "_req"},   DW'(ddr_if.ddr_fifo_req), '0);
        check({tag, "_addr"},  DW'(ddr_if.ddr_st_addr_out), '0);
        check({tag, "_len"},   DW'(ddr_if.ddr_len), '0);
        check({tag, "_state"}, DW'(dbg_state), DW'(ST_IDLE));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // all three channels at once from rr_ptr=0: two batches served 0,1,2
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < N_CH; c++) begin
                set_ch(c, AW'(32'h2000 + b*32'h800 + c*32'h100), LW'(2));
                expect_cmd(AW'(32'h2000 + b*32'h800 + c*32'h100), LW'(2));
                expect_done(N_CH'(1 << c), LW'(2));
            end
            pulse(3'b111);
            wait_drain(200);
        end

        // single request: ddr_conf appears on the third edge after the pulse
        set_ch(1, 32'h1000, 24'd4);
        expect_cmd(32'h1000, 24'd4);
        expect_done(3'b010, 24'd4);
        pulse(3'b010);
        check("lat_edge1", DW'(ddr_if.ddr_conf), '0);
        @(negedge clk);
        check("lat_edge2", DW'(ddr_if.ddr_conf), '0);
        @(negedge clk);
        check("lat_edge3", DW'(ddr_if.ddr_conf), DW'(1'b1));
        check("stream_empty_view", DW'(ch_fifo_empty), DW'(3'b101));
        check("stream_req", DW'(ddr_if.ddr_fifo_req), DW'(1'b1));
        check("stream_state", DW'(dbg_state), DW'(ST_STREAM));
        wait_drain(100);
        check("t1_busy_after", DW'(ch_busy), '0);

        // forced channel 2 with ch0 also pending; ch0 waits until round-robin
        arb_mode = 1'b1;
        force_ch = 2'd2;
        set_ch(0, 32'h3000, 24'd3);
        set_ch(2, 32'h3200, 24'd3);
        expect_cmd(32'h3200, 24'd3);
        expect_done(3'b100, 24'd3);
        pulse(3'b101);
        wait_drain(100);
        force_ch = 2'd3;
        repeat (10) @(negedge clk);
        check("force_hold_busy", DW'(ch_busy), DW'(3'b001));
        check("force_hold_state", DW'(dbg_state), DW'(ST_IDLE));
        expect_cmd(32'h3000, 24'd3);
        expect_done(3'b001, 24'd3);
        arb_mode = 1'b0;
        wait_drain(100);

        // zero-length request: no command, done right after ISSUE
        set_ch(0, 32'h4000, 24'd0);
        expect_done(3'b001, 24'd0);
        pulse(3'b001);
        @(negedge clk);
        @(negedge clk);
        check("len0_done", DW'(ch_done), DW'(3'b001));
        check("len0_conf", DW'(ddr_if.ddr_conf), '0);
        check("len0_busy", DW'(ch_busy), '0);
        wait_drain(50);

        // conf while busy sets sticky err; empty toggles during the stream
        toggle_en = 1'b1;
        set_ch(1, 32'h5000, 24'd5);
        expect_cmd(32'h5000, 24'd5);
        expect_done(3'b010, 24'd5);
        pulse(3'b010);
        set_ch(1, 32'h5500, 24'd9);
        pulse(3'b010);
        check("err_set", DW'(ch_err), DW'(3'b010));
        wait_drain(200);
        toggle_en = 1'b0;
        repeat (2) @(negedge clk);
        check("err_sticky", DW'(ch_err), DW'(3'b010));

        // reset after two of eight beats: service abandoned, no done pulse
        set_ch(0, 32'h6000, 24'd8);
        expect_cmd(32'h6000, 24'd8);
        pulse(3'b001);
        n = 0;
        while (!ddr_if.ddr_conf && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_conf_seen", DW'(ddr_if.ddr_conf), DW'(1'b1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", DW'(ch_busy), '0);
        check("post_rst_state", DW'(dbg_state), DW'(ST_IDLE));
        check("post_rst_queue", DW'(conf_exp_q.size() + done_exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
